// File: rtl/unpool1_stream.sv
// 2x2 unpooling stage: one-row line buffer, FILL then two EMIT rows.
// Define UNPOOL1_ZERO_FILL_EN for zero-insertion instead of replication.
module unpool1_stream #(
  parameter int CH   = 20,
  parameter int W_IN = 12,
  parameter int H_IN = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH-1:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH-1:0]               out_data,
  output logic [$clog2(2*H_IN)-1:0]   out_row,
  output logic [$clog2(2*W_IN)-1:0]   out_col,
  output logic                        out_last
);

  localparam int RW  = $clog2(2*H_IN);
  localparam int CW  = $clog2(2*W_IN);
  localparam int ICW = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int RRW = (H_IN > 1) ? $clog2(H_IN) : 1;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] EMIT0 = 2'd1;
  localparam logic [1:0] EMIT1 = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [ICW-1:0] in_col_q, in_col_d;
  logic [RRW-1:0] r_q, r_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [CH-1:0]  out_data_q, out_data_d;
  logic [RW-1:0]  out_row_q, out_row_d;
  logic [CW-1:0]  out_col_q, out_col_d;
  logic           out_last_q, out_last_d;

  logic [CH-1:0]  buf_q [W_IN];

  logic           in_fire, out_fire;
  logic           load, byp;
  logic [CW-1:0]  ncol;
  logic [RW-1:0]  nrow;
  logic [ICW-1:0] ridx;
  logic [CH-1:0]  rdat;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    r_d         = r_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    load        = 1'b0;
    byp         = 1'b0;
    ncol        = out_col_q + 1'b1;
    nrow        = out_row_q;
    unique case (state_q)
      FILL: begin
        in_ready_d = 1'b1;
        if (in_fire) begin
          in_col_d = in_col_q + 1'b1;
          if (in_col_q == ICW'(W_IN-1)) begin
            in_col_d    = '0;
            state_d     = EMIT0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            ncol        = '0;
            nrow        = RW'({r_q, 1'b0});
            load        = 1'b1;
            byp         = (W_IN == 1);
          end
        end
      end
      EMIT0, EMIT1: begin
        if (out_fire) begin
          if (out_col_q == CW'(2*W_IN-1)) begin
            if (state_q == EMIT0) begin
              state_d = EMIT1;
              ncol    = '0;
              nrow    = out_row_q + 1'b1;
              load    = 1'b1;
            end else begin
              state_d     = FILL;
              out_valid_d = 1'b0;
              in_ready_d  = 1'b1;
              out_last_d  = 1'b0;
              out_data_d  = '0;
              r_d = (r_q == RRW'(H_IN-1)) ? '0 : r_q + 1'b1;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
    ridx = ICW'(ncol >> 1);
    rdat = byp ? in_data : buf_q[ridx];
`ifdef UNPOOL1_ZERO_FILL_EN
    rdat = rdat & {CH{~nrow[0] & ~ncol[0]}};
`endif
    if (load) begin
      out_col_d  = ncol;
      out_row_d  = nrow;
      out_data_d = rdat;
      out_last_d = (nrow == RW'(2*H_IN-1)) &&
                   (ncol == CW'(2*W_IN-1));
    end
  end

  // Line buffer is deliberately unreset; EMIT only follows a full row write.
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[in_col_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      in_col_q    <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

endmodule
